// File: rtl/program_counter_stack.sv
// Program counter with an optional hardware return stack, compiled in by `define PC_RETURN_STACK_EN.
// One command per edge, priority reset > stall > ret > call > load > branch > incr > hold.
module program_counter_stack #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       load,
  input  logic [WIDTH-1:0]           addr,
  input  logic                       branch,
  input  logic [WIDTH-1:0]           offset,
  input  logic                       incr,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       overflow_err,
  output logic                       underflow_err
);
  localparam int SP_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_pc = RESET_VECTOR;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_pc_nxt;

  assign w_pc_inc = r_pc + WIDTH'(1);
  assign pc       = r_pc;

  // Commands below call/ret; shared by both builds.
  always_comb begin
    w_pc_seq = r_pc;
    if (load)        w_pc_seq = addr;
    else if (branch) w_pc_seq = r_pc + offset;
    else if (incr)   w_pc_seq = w_pc_inc;
  end

`ifdef PC_RETURN_STACK_EN
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [SP_W-1:0]  r_sp  = '0;
  logic             r_ovf = 1'b0;
  logic             r_unf = 1'b0;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_full   = (r_sp == SP_W'(DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));

  always_comb begin
    w_pc_nxt  = w_pc_seq;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (ret) begin
      w_pc_nxt = r_pc;
      if (w_empty) begin
        w_unf_set = 1'b1;
      end else begin
        w_pc_nxt = r_stack[w_rd_idx];
        w_pop    = 1'b1;
      end
    end else if (call) begin
      w_pc_nxt = r_pc;
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_pc_nxt = addr;
        w_push   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc  <= RESET_VECTOR;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_pc_nxt;
      if (w_push)      r_sp <= r_sp + SP_W'(1);
      else if (w_pop)  r_sp <= r_sp - SP_W'(1);
      if (w_ovf_set)   r_ovf <= 1'b1;
      if (w_unf_set)   r_unf <= 1'b1;
    end
  end

  // Entries above sp are unreachable, so the storage itself is never cleared.
  always_ff @(posedge clock) begin
    if (!reset && !stall && w_push) r_stack[w_wr_idx] <= w_pc_inc;
  end

  assign sp            = r_sp;
  assign stack_full    = w_full;
  assign stack_empty   = w_empty;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;
`else
  logic w_unused_ret;

  assign w_unused_ret = ret;
  assign w_pc_nxt     = call ? addr : w_pc_seq;

  always_ff @(posedge clock) begin
    if (reset)       r_pc <= RESET_VECTOR;
    else if (!stall) r_pc <= w_pc_nxt;
  end

  assign sp            = '0;
  assign stack_full    = 1'b0;
  assign stack_empty   = 1'b1;
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed and random bench for program_counter_stack; adapts to the PC_RETURN_STACK_EN build.
module tb_program_counter_stack;
  localparam int          WIDTH = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RV    = 16'h0000;
`ifdef PC_RETURN_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        load = 1'b0;
  logic [15:0] addr = '0;
  logic        branch = 1'b0;
  logic [15:0] offset = '0;
  logic        incr = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] pc;
  logic [2:0]  sp;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow_err;
  logic        underflow_err;

  always #5 clock = ~clock;

  program_counter_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .stall(stall), .load(load), .addr(addr),
    .branch(branch), .offset(offset), .incr(incr), .call(call), .ret(ret),
    .pc(pc), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  sp;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_pc = RV;
  int          m_sp = 0;
  logic [15:0] m_stk [DEPTH];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rs, input logic st, input logic rt,
                      input logic cl, input logic ld, input logic br, input logic inc,
                      input logic [15:0] a, input logic [15:0] off);
    exp_t e;
    reset = rs; stall = st; ret = rt; call = cl; load = ld;
    branch = br; incr = inc; addr = a; offset = off;
    if (rs) begin
      m_pc = RV; m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!st) begin
      if (rt && EN) begin
        if (m_sp == 0) m_unf = 1'b1;
        else begin m_sp--; m_pc = m_stk[m_sp]; end
      end else if (cl && EN) begin
        if (m_sp == DEPTH) m_ovf = 1'b1;
        else begin m_stk[m_sp] = m_pc + 16'd1; m_sp++; m_pc = a; end
      end else if (cl || ld) m_pc = a;
      else if (br)           m_pc = m_pc + off;
      else if (inc)          m_pc = m_pc + 16'd1;
    end
    e.pc = m_pc; e.sp = 3'(m_sp); e.full = (m_sp == DEPTH); e.empty = (m_sp == 0);
    e.ovf = m_ovf; e.unf = m_unf;
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    check({tag, ".pc"}, pc, e.pc);
    check({tag, ".sp"}, sp, e.sp);
    check({tag, ".full"}, stack_full, e.full);
    check({tag, ".empty"}, stack_empty, e.empty);
    check({tag, ".ovf"}, overflow_err, e.ovf);
    check({tag, ".unf"}, underflow_err, e.unf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("init.pc", pc, RV);
    check("init.sp", sp, 0);

    step("rst", 1,0,0,0,0,0,0, 16'h0, 16'h0);
    check("r41.pc0", pc, 16'h0000);
    step("inc1", 0,0,0,0,0,0,1, 16'h0, 16'h0);
    check("r41.pc1", pc, 16'h0001);
    step("inc2", 0,0,0,0,0,0,1, 16'h0, 16'h0);
    step("inc3", 0,0,0,0,0,0,1, 16'h0, 16'h0);
    check("r41.pc3", pc, 16'h0003);
    step("rst_inc", 1,0,0,0,0,0,1, 16'h0, 16'h0);
    check("r41.rst", pc, 16'h0000);

    step("ld_fffe", 0,0,0,0,1,0,0, 16'hFFFE, 16'h0);
    check("r42.fffe", pc, 16'hFFFE);
    step("inc_ffff", 0,0,0,0,0,0,1, 16'h0, 16'h0);
    check("r42.ffff", pc, 16'hFFFF);
    step("inc_wrap", 0,0,0,0,0,0,1, 16'h0, 16'h0);
    check("r42.wrap", pc, 16'h0000);

    step("ld_10", 0,0,0,0,1,0,0, 16'h0010, 16'h0);
    step("br_m16", 0,0,0,0,0,1,0, 16'h0, 16'hFFF0);
    check("r43.neg", pc, 16'h0000);
    step("br_p5", 0,0,0,0,0,1,0, 16'h0, 16'h0005);
    check("r43.pos", pc, 16'h0005);

    step("ld_100", 0,0,0,0,1,0,0, 16'h0100, 16'h0);
    step("call_200", 0,0,0,1,0,0,0, 16'h0200, 16'h0);
    check("r44.call_pc", pc, 16'h0200);
    step("ret", 0,0,1,0,0,0,0, 16'h0, 16'h0);
`ifdef PC_RETURN_STACK_EN
    check("r44.ret_pc", pc, 16'h0101);
    check("r44.ret_empty", stack_empty, 1'b1);
`else
    check("r39.ret_ignored", pc, 16'h0200);
`endif
    step("ret_inc", 0,0,1,0,0,0,1, 16'h0, 16'h0);
`ifdef PC_RETURN_STACK_EN
    check("r25.hold", pc, 16'h0101);
    check("r25.unf", underflow_err, 1'b1);
`else
    check("r39.fallthru", pc, 16'h0201);
`endif

    step("rst2", 1,0,0,0,0,0,0, 16'h0, 16'h0);
    step("ld_10b", 0,0,0,0,1,0,0, 16'h0010, 16'h0);
    for (int i = 1; i <= 5; i++)
      step("call_n", 0,0,0,1,0,0,0, 16'(i * 16'h0100), 16'h0);
`ifdef PC_RETURN_STACK_EN
    check("r45.pc", pc, 16'h0400);
    check("r45.sp", sp, 3'd4);
    check("r45.ovf", overflow_err, 1'b1);
`else
    check("r46.pc", pc, 16'h0500);
    check("r46.sp", sp, 3'd0);
`endif
    for (int i = 0; i < 5; i++)
      step("ret_n", 0,0,1,0,0,0,0, 16'h0, 16'h0);
`ifdef PC_RETURN_STACK_EN
    check("r45.unf_pc", pc, 16'h0011);
    check("r45.unf", underflow_err, 1'b1);
`endif
    step("sticky", 0,0,0,0,0,0,1, 16'h0, 16'h0);
    step("rst_stall", 1,1,0,0,0,0,0, 16'h0, 16'h0);
    check("r34.pc", pc, RV);
    check("r34.unf", underflow_err, 1'b0);

    step("ld_30", 0,0,0,0,1,0,0, 16'h0030, 16'h0);
    step("stall_mix", 0,1,0,1,1,0,1, 16'h0077, 16'h0);
    check("r46.stall", pc, 16'h0030);
    step("call_mix", 0,0,0,1,1,0,1, 16'h0077, 16'h0);
    check("r46.win", pc, 16'h0077);
`ifdef PC_RETURN_STACK_EN
    check("r46.sp", sp, 3'd1);
`endif
    step("rst_call", 1,0,0,1,0,0,0, 16'h0123, 16'h0);
    check("r36.pc", pc, RV);
    check("r36.sp", sp, 3'd0);

    step("ld_ffff", 0,0,0,0,1,0,0, 16'hFFFF, 16'h0);
    step("call_40", 0,0,0,1,0,0,0, 16'h0040, 16'h0);
    step("ret_wrap", 0,0,1,0,0,0,0, 16'h0, 16'h0);
`ifdef PC_RETURN_STACK_EN
    check("r31.wrap", pc, 16'h0000);
`endif
    step("ld_prio", 0,0,0,0,1,1,1, 16'h0AAA, 16'h0100);
    check("prio.load", pc, 16'h0AAA);
    step("br_prio", 0,0,0,0,0,1,1, 16'h0, 16'h0010);
    check("prio.branch", pc, 16'h0ABA);
    step("hold", 0,0,0,0,0,0,0, 16'h1234, 16'h0);
    check("hold", pc, 16'h0ABA);

    for (int i = 0; i < 200; i++)
      step("rnd", $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/program_counter_stack.md
PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 The module SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 16: PC and address width in bits.
REQ-003 Parameter DEPTH, default 4: return-stack entries, at least 1.
REQ-004 Parameter RESET_VECTOR, default 0: PC value loaded on reset, WIDTH bits.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hold all state this cycle.
REQ-008 load  input  1  absolute jump to addr.
REQ-009 addr  input  WIDTH  jump or call target.
REQ-010 branch  input  1  relative jump by offset.
REQ-011 offset  input  WIDTH  two's-complement branch displacement.
REQ-012 incr  input  1  advance PC by 1.
REQ-013 call  input  1  push PC+1, then jump to addr.
REQ-014 ret  input  1  pop the stack top into PC.
REQ-015 pc  output  WIDTH  registered program counter.
REQ-016 sp  output  $clog2(DEPTH+1)  current stack occupancy, 0..DEPTH.
REQ-017 stack_full  output  1  high when sp==DEPTH.
REQ-018 stack_empty  output  1  high when sp==0.
REQ-019 overflow_err  output  1  sticky flag: call issued while full.
REQ-020 underflow_err  output  1  sticky flag: ret issued while empty.

Function
REQ-021 All state SHALL update only on the rising edge of clock, so a command sampled at edge N is visible on pc and sp after edge N with 1-cycle latency.
REQ-022 Command priority per edge SHALL be: reset > stall > ret > call > load > branch > incr > hold; only the highest-priority asserted command takes effect.
REQ-023 stall SHALL freeze pc, sp, stack contents and error flags.
REQ-024 ret when not empty: pc <= stack[sp-1], and sp <= sp-1.
REQ-025 ret when empty: pc and sp hold, and underflow_err <= 1.
REQ-026 call when not full: stack[sp] <= pc+1, sp <= sp+1, and pc <= addr.
REQ-027 call when full: pc, sp and stack hold, and overflow_err <= 1.
REQ-028 load: pc <= addr.
REQ-029 branch: pc <= pc + offset, computed modulo 2^WIDTH.
REQ-030 incr: pc <= pc + 1, computed modulo 2^WIDTH, so all-ones wraps to 0.
REQ-031 The pushed return address SHALL also wrap, so pc = all-ones pushes 0.
REQ-032 stack_full and stack_empty SHALL be decoded combinationally from registered sp.
REQ-033 Error flags SHALL clear only on reset.

Reset
REQ-034 reset high at an edge SHALL set pc <= RESET_VECTOR, sp <= 0, overflow_err <= 0 and underflow_err <= 0, overriding any concurrent command including stall.
REQ-035 Stack contents SHALL NOT be cleared by reset, because sp==0 makes them unreachable.
REQ-036 Reset asserted mid-sequence (for example, same edge as a call) SHALL discard the command entirely.
REQ-037 Before the first reset, pc SHALL initialise to RESET_VECTOR and sp to 0.

Configuration
REQ-038 The macro PC_RETURN_STACK_EN SHALL compile the return stack in; with PC_RETURN_STACK_EN defined, REQ-024..REQ-027 apply.
REQ-039 Without PC_RETURN_STACK_EN, call SHALL behave as load (pc <= addr) and ret SHALL be ignored (falls through to lower-priority commands).
REQ-040 Without PC_RETURN_STACK_EN, sp SHALL read constant 0, stack_empty 1, stack_full 0, and both error flags 0, with no stack storage inferred.

Verification
REQ-041 Reset, then incr x3 -> pc = 0,1,2,3; assert reset with incr -> pc = 0 on the next edge.
REQ-042 WIDTH=16, load addr=16'hFFFE, then incr x2 -> pc = FFFE, FFFF, 0000.
REQ-043 pc=16'h0010, branch offset=16'hFFF0 (-16) -> pc=0000; then branch offset=16'h0005 -> pc=0005.
REQ-044 pc=0x0100, call addr=0x0200 -> pc=0200, sp=1; then ret -> pc=0101, sp=0, stack_empty=1.
REQ-045 DEPTH=4: five calls -> sp=4, stack_full=1, overflow_err=1, pc = 4th target; one ret on an empty stack after four pops -> underflow_err=1 and pc holds.
REQ-046 call+load+incr together with stall=1 -> no change; the same inputs with stall=0 -> call wins; build without PC_RETURN_STACK_EN -> call acts as load, and sp stays 0.
